// File: rtl/y86_defs.sv
// Shared Y86-64 definitions: instruction codes, condition ifun codes, ALU op
// codes, the "no register" ID, the reset condition-code value and the
// execute-stage run/halt state type.
package y86_defs;

    // Instruction codes
    localparam logic [3:0] IcHalt  = 4'h0;
    localparam logic [3:0] IcNop   = 4'h1;
    localparam logic [3:0] IcRrmov = 4'h2;  // also cmovXX
    localparam logic [3:0] IcIrmov = 4'h3;
    localparam logic [3:0] IcRmmov = 4'h4;
    localparam logic [3:0] IcMrmov = 4'h5;
    localparam logic [3:0] IcOpq   = 4'h6;
    localparam logic [3:0] IcJxx   = 4'h7;
    localparam logic [3:0] IcCall  = 4'h8;
    localparam logic [3:0] IcRet   = 4'h9;
    localparam logic [3:0] IcPush  = 4'hA;
    localparam logic [3:0] IcPop   = 4'hB;

    // Condition function codes for jXX / cmovXX
    localparam logic [3:0] CondAlways = 4'h0;
    localparam logic [3:0] CondLe     = 4'h1;
    localparam logic [3:0] CondL      = 4'h2;
    localparam logic [3:0] CondE      = 4'h3;
    localparam logic [3:0] CondNe     = 4'h4;
    localparam logic [3:0] CondGe     = 4'h5;
    localparam logic [3:0] CondG      = 4'h6;

    // ALU operation codes
    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluSub = 2'b01;
    localparam logic [1:0] AluAnd = 2'b10;
    localparam logic [1:0] AluXor = 2'b11;

    localparam logic [3:0] RegNone = 4'hF;

    // {ZF,SF,OF} after reset
    localparam logic [2:0] CcReset = 3'b100;

    typedef enum logic {
        StRun,
        StHalted
    } exec_state_e;

endpackage

// File: rtl/exec_stage_y86_if.sv
// Bus bundle around the execute stage: decode-side request (e_*), ALU
// operand/result path (alu_*) and the E->M pipeline register (m_*).
// Modports: master = surrounding pipeline (decode, ALU, memory stage),
//           slave  = the execute stage itself.
interface exec_stage_y86_if #(
    parameter int unsigned W = 64
);
    logic         e_valid;
    logic         e_ready;
    logic [3:0]   e_icode;
    logic [3:0]   e_ifun;
    logic [W-1:0] e_valA;
    logic [W-1:0] e_valB;
    logic [W-1:0] e_valC;
    logic [3:0]   e_dstE;
    logic [3:0]   e_dstM;

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_res;
    logic         alu_ovf;
    logic         alu_zero;

    logic         m_valid;
    logic         m_ready;
    logic [3:0]   m_icode;
    logic         m_cnd;
    logic [W-1:0] m_valE;
    logic [W-1:0] m_valA;
    logic [3:0]   m_dstE;
    logic [3:0]   m_dstM;

    modport master (
        output e_valid, e_icode, e_ifun, e_valA, e_valB, e_valC, e_dstE, e_dstM,
        output alu_res, alu_ovf, alu_zero, m_ready,
        input  e_ready, alu_a, alu_b, alu_op,
        input  m_valid, m_icode, m_cnd, m_valE, m_valA, m_dstE, m_dstM
    );

    modport slave (
        input  e_valid, e_icode, e_ifun, e_valA, e_valB, e_valC, e_dstE, e_dstM,
        input  alu_res, alu_ovf, alu_zero, m_ready,
        output e_ready, alu_a, alu_b, alu_op,
        output m_valid, m_icode, m_cnd, m_valE, m_valA, m_dstE, m_dstM
    );
endinterface

// File: rtl/exec_stage_y86_cond_eval.sv
// Combinational jXX/cmovXX condition evaluation.
// Ports: cc   - {ZF,SF,OF}
//        ifun - condition function code
//        cnd  - condition holds (0 for undefined codes)
module cond_eval
    import y86_defs::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);
    logic zf, sf, of;
    assign zf = cc[2];
    assign sf = cc[1];
    assign of = cc[0];

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            CondAlways: cnd = 1'b1;
            CondLe:     cnd = (sf ^ of) | zf;
            CondL:      cnd = sf ^ of;
            CondE:      cnd = zf;
            CondNe:     cnd = ~zf;
            CondGe:     cnd = ~(sf ^ of);
            CondG:      cnd = ~(sf ^ of) & ~zf;
            default:    cnd = 1'b0;
        endcase
    end
endmodule

// File: rtl/exec_stage_y86.sv
// Y86-64 execute stage. Selects ALU operands/operation, owns the condition
// codes, evaluates jXX/cmovXX conditions and registers results into the E->M
// pipeline register with a valid/ready handshake. HALT, unknown icodes and
// OPq with an undefined function stop the stage until reset.
// Ports: clk, reset (synchronous, active-high)
//        m_exc  - (EXC_GATE_EN builds only) suppresses condition-code updates
//        bus    - exec_stage_y86_if slave: e_* request, alu_* path, m_* register
//        cc     - {ZF,SF,OF}
//        halted - stage no longer accepts instructions
// Optional feature macro: EXC_GATE_EN
module exec_stage_y86
    import y86_defs::*;
#(
    parameter int unsigned W          = 64,
    parameter int unsigned STACK_STEP = 8,
    parameter logic [3:0]  RNONE      = RegNone
) (
    input  logic               clk,
    input  logic               reset,
`ifdef EXC_GATE_EN
    input  logic               m_exc,
`endif
    exec_stage_y86_if.slave    bus,
    output logic [2:0]         cc,
    output logic               halted
);
    exec_state_e state_q, state_d;
    logic [2:0]  cc_q;
    logic        m_valid_q;
    logic        fire;
    logic        cond_raw;
    logic        cnd;
    logic        halt_trig;
    logic        cc_upd;
    logic        exc_gate;
    logic [3:0]  icode;
    logic [3:0]  ifun;

    assign icode  = bus.e_icode;
    assign ifun   = bus.e_ifun;
    assign halted = (state_q == StHalted);
    assign cc     = cc_q;

    assign bus.e_ready = !halted && (!m_valid_q || bus.m_ready);
    assign bus.m_valid = m_valid_q;
    assign fire        = bus.e_valid && bus.e_ready;

    // Conditions see the registered cc, never the update in flight.
    cond_eval u_cond_eval (
        .cc   (cc_q),
        .ifun (ifun),
        .cnd  (cond_raw)
    );
    assign cnd = ((icode == IcRrmov) || (icode == IcJxx)) ? cond_raw : 1'b0;

    assign halt_trig = (icode == IcHalt) || (icode > IcPop) ||
                       ((icode == IcOpq) && (ifun > 4'd3));

`ifdef EXC_GATE_EN
    assign exc_gate = m_exc;
`else
    assign exc_gate = 1'b0;
`endif

    // ifun <= 3 already excludes the halting OPq forms.
    assign cc_upd = fire && (icode == IcOpq) && (ifun <= 4'd3) && !exc_gate;

    always_comb begin
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        bus.alu_op = AluAdd;
        case (icode)
            IcOpq: begin
                bus.alu_a  = bus.e_valB;
                bus.alu_b  = bus.e_valA;
                bus.alu_op = ifun[1:0];
            end
            IcRrmov: bus.alu_a = bus.e_valA;
            IcIrmov: bus.alu_a = bus.e_valC;
            IcRmmov, IcMrmov: begin
                bus.alu_a = bus.e_valB;
                bus.alu_b = bus.e_valC;
            end
            IcCall, IcPush: begin
                bus.alu_a  = bus.e_valB;
                bus.alu_b  = W'(STACK_STEP);
                bus.alu_op = AluSub;
            end
            IcRet, IcPop: begin
                bus.alu_a = bus.e_valB;
                bus.alu_b = W'(STACK_STEP);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun:    if (fire && halt_trig) state_d = StHalted;
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            cc_q        <= CcReset;
            m_valid_q   <= 1'b0;
            bus.m_icode <= '0;
            bus.m_cnd   <= 1'b0;
            bus.m_valE  <= '0;
            bus.m_valA  <= '0;
            bus.m_dstE  <= RNONE;
            bus.m_dstM  <= RNONE;
        end else begin
            state_q <= state_d;
            if (cc_upd) cc_q <= {bus.alu_zero, bus.alu_res[W-1], bus.alu_ovf};
            if (fire) begin
                m_valid_q   <= 1'b1;
                bus.m_icode <= icode;
                bus.m_cnd   <= cnd;
                bus.m_valE  <= bus.alu_res;
                bus.m_valA  <= bus.e_valA;
                // A failed cmov must not write its destination.
                bus.m_dstE  <= ((icode == IcRrmov) && !cnd) ? RNONE : bus.e_dstE;
                bus.m_dstM  <= bus.e_dstM;
            end else if (bus.m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: doc/exec_stage_y86.md
Name: exec_stage_y86

Overview:
Execute stage of the pipelined Y86-64 core, directly upstream of the 64-bit ALU.
- Per instruction from decode: selects ALU operands and operation, owns the condition-code register (ZF/SF/OF), and evaluates the jXX/cmovXX condition.
- Registers the result into the E->M pipeline register using a valid/ready handshake.
- Latches a halted state on HALT or an invalid instruction.

Parameters:
W, 64, datapath width (valA/valB/valC/valE)
STACK_STEP, 8, stack pointer adjust for call/ret/push/pop
RNONE, 4'hF, register ID meaning "no destination"

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
e_valid  in  1  decode presents an instruction
e_ready  out  1  stage accepts the instruction this cycle
e_icode  in  4  instruction code
e_ifun  in  4  function code
e_valA  in  W  operand A
e_valB  in  W  operand B
e_valC  in  W  constant
e_dstE  in  4  ALU destination register
e_dstM  in  4  memory destination register
alu_a  out  W  ALU operand a
alu_b  out  W  ALU operand b
alu_op  out  2  ALU operation: 00 ADD, 01 SUB (a-b), 10 AND, 11 XOR
alu_res  in  W  ALU result
alu_ovf  in  1  ALU overflow
alu_zero  in  1  ALU zero flag
m_valid  out  1  M register holds a valid instruction
m_ready  in  1  memory stage consumes the M register
m_icode  out  4  registered icode
m_cnd  out  1  registered condition result
m_valE  out  W  registered ALU result
m_valA  out  W  registered valA (store data / return path)
m_dstE  out  4  registered dstE, forced to RNONE on a failed cmov
m_dstM  out  4  registered dstM
cc  out  3  {ZF,SF,OF}
halted  out  1  stage has stopped accepting instructions

Behaviour:
Clocking and reset:
- Single clock clk; reset is synchronous and active-high.
- Reset values: cc=3'b100, m_valid=0, m_icode=0, m_cnd=0, m_valE=0, m_valA=0, m_dstE=RNONE, m_dstM=RNONE, halted=0.
- Reset wins over any transfer in the same cycle.

Operand selection (combinational from e_*):
- OPQ(6): a=valB, b=valA, op=ifun[1:0].
- RRMOV/CMOV(2): a=valA, b=0, ADD.
- IRMOV(3): a=valC, b=0, ADD.
- RMMOV(4), MRMOV(5): a=valB, b=valC, ADD.
- CALL(8), PUSH(A): a=valB, b=STACK_STEP, SUB.
- RET(9), POP(B): a=valB, b=STACK_STEP, ADD.
- All other icodes: a=0, b=0, ADD.

Handshake:
- e_ready = !halted && (!m_valid || m_ready).
- fire = e_valid && e_ready. Latency is 1 cycle.
- On fire: M register loads alu_res, valA, icode, dstM, cnd, and dstE (dstE replaced by RNONE when icode=2 and cnd=0).
- If m_ready is asserted without fire, m_valid clears.
- While stalled (m_valid && !m_ready): all M fields and cc hold.

Condition evaluation:
- Conditions are evaluated from the current registered cc, not the in-flight update.
- ifun codes: 0 always, 1 le (SF^OF)|ZF, 2 l SF^OF, 3 e ZF, 4 ne !ZF, 5 ge !(SF^OF), 6 g !(SF^OF)&!ZF.
- ifun>6 gives cnd=0.
- cnd is computed for icode 2 and 7 only; it is 0 for all other icodes.

CC update:
- Only on fire of OPQ with ifun<=3.
- cc <= {alu_zero, alu_res[W-1], alu_ovf}.

FSM RUN/HALTED:
- RUN -> HALTED on fire of any of: icode 0, icode > 4'hB, or OPQ with ifun>3.
- The offending instruction still enters the M register, and cc does not update for it.
- HALTED holds e_ready=0 and leaves only on reset. The M register drains normally while halted.

Optional Feature:
EXC_GATE_EN:
- With the macro defined, add input port m_exc (1 bit). While m_exc=1, cc does not update, and instructions still transfer.
- Without the macro, the port is absent and cc updates unconditionally per the CC update rule.

Decomposition:
- Shared package/header y86_defs holds: the icode constants (HALT..POPQ), condition ifun codes, ALU op codes (ADD/SUB/AND/XOR), RNONE, and the reset cc value.
- One natural sub-module, cond_eval: combinational (cc, ifun) -> cnd, reused later by the fetch-stage branch logic.

Test Plan:
- OPQ subq: valA=5, valB=5, ALU result 0 -> alu_a=5, alu_b=5, alu_op=01; next cycle m_valE=0, m_valid=1, cc=3'b100.
- addq with alu_res=64'h8000_0000_0000_0000 and alu_ovf=1 -> cc=3'b011; then cmovl (ifun=2) -> m_cnd=0, m_dstE=RNONE.
- Hold m_ready=0 for 3 cycles with e_valid=1 -> e_ready=0 from the second cycle, M fields stable; release -> next instruction loads one cycle later.
- pushq with valB=0x100 -> alu_a=0x100, alu_b=8, alu_op=01; next cycle m_valE=0xF8 from the ALU.
- HALT (icode 0) fires -> halted=1, e_ready=0 forever after, m_valid drains when m_ready=1; assert reset -> halted=0, cc=3'b100.
- EXC_GATE_EN build: subq with m_exc=1 producing a zero result -> cc unchanged, instruction still transfers.
